// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: decodes PS/2 make/break scancodes (incl. E0 extended) into a held game key code
module ps2_key_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic [2:0] key,
  output logic       key_event,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state, next_state;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic sync_clk, sync_data, clk_prev, fall;
  logic [3:0] bitcnt;
  logic [9:0] sr;
  logic [TW-1:0] tcnt;
  logic ext, brk, err_c, valid_c, abort, ok, pfx;
  logic [7:0] b;
  logic [2:0] code, new_key;
  assign sync_clk  = clk_sync[SYNC_STAGES-1];
  assign sync_data = data_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~sync_clk;
  assign ok        = sr[9] & (^sr[8:0]);
  assign b         = sr[7:0];
  assign pfx       = (b == 8'hE0) || (b == 8'hF0);
  // Bring the asynchronous PS/2 lines into the clk domain; idle bus is high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2_data};
      clk_prev  <= sync_clk;
    end
  // Frame FSM state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next_state;
  // Frame FSM transitions plus error / byte-valid strobes
  always_comb begin
    next_state = state;
    err_c      = 1'b0;
    valid_c    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE:
        if (fall) begin
          next_state = sync_data ? IDLE : SHIFT;
          err_c      = sync_data;
        end
      SHIFT:
        if (fall) next_state = (bitcnt == 4'd9) ? CHECK : SHIFT;
        else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          next_state = IDLE;
          err_c      = 1'b1;
          abort      = 1'b1;
        end
      CHECK: begin
        next_state = IDLE;
        valid_c    = ok;
        err_c      = ~ok;
        abort      = ~ok;
      end
      default: next_state = IDLE;
    endcase
  end
  // Bit shifter (LSB first, ends with parity at [8] and stop at [9]), bit and timeout counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bitcnt <= '0;
      sr     <= '0;
      tcnt   <= '0;
    end else begin
      bitcnt <= (state == IDLE) ? 4'd0 : (state == SHIFT && fall) ? bitcnt + 4'd1 : bitcnt;
      sr     <= (state == SHIFT && fall) ? {sync_data, sr[9:1]} : sr;
      tcnt   <= (state == SHIFT && !fall) ? tcnt + 1'b1 : '0;
    end
  // Scancode lookup and the key value a non-prefix byte would produce
  always_comb begin
    code    = ext ? (b == 8'h75 ? 3'd3 : b == 8'h6B ? 3'd5 : b == 8'h74 ? 3'd6 : b == 8'h72 ? 3'd7 : 3'd0)
                  : (b == 8'h2D ? 3'd1 : b == 8'h29 ? 3'd2 : b == 8'h1A ? 3'd4 : 3'd0);
    new_key = (code == 3'd0) ? key : !brk ? code : (code == key) ? 3'd0 : key;
  end
  // Prefix flags, held key and the one-cycle event/error pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      key       <= 3'd0;
      key_event <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_c;
      key_event <= valid_c && !pfx && (new_key != key);
      if (abort) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (valid_c) begin
        if (b == 8'hE0) ext <= 1'b1;
        else if (b == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          key <= new_key;
        end
      end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and random PS/2 frames checked against a scancode-level model
module tb_ps2_key_decoder;
  localparam int SS = 2;
  localparam int TO = 200;
  localparam int H  = 8;
  logic clk = 1'b0, rst = 1'b1, PS2_clk = 1'b1, PS2_data = 1'b1;
  logic [2:0] key;
  logic key_event, frame_err;
  int total = 0, bad = 0;
  int ev_cnt = 0, err_cnt = 0, both_cnt = 0;
  int m_key = 0;
  bit m_ext = 0, m_brk = 0;
  ps2_key_decoder #(.SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .PS2_clk(PS2_clk), .PS2_data(PS2_data),
    .key(key), .key_event(key_event), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (key_event) ev_cnt++;
    if (frame_err) err_cnt++;
    if (key_event && frame_err) both_cnt++;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int lut(input bit e, input logic [7:0] c);
    if (!e) return c == 8'h2D ? 1 : c == 8'h29 ? 2 : c == 8'h1A ? 4 : 0;
    return c == 8'h75 ? 3 : c == 8'h6B ? 5 : c == 8'h74 ? 6 : c == 8'h72 ? 7 : 0;
  endfunction
  function automatic void model(input logic [7:0] c, input bit err);
    int g;
    if (err) begin
      m_ext = 0;
      m_brk = 0;
    end else if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else begin
      g = lut(m_ext, c);
      if (g != 0 && !m_brk) m_key = g;
      else if (g != 0 && m_key == g) m_key = 0;
      m_ext = 0;
      m_brk = 0;
    end
  endfunction
  task automatic ps2_bit(input bit d);
    @(negedge clk) PS2_data = d;
    repeat (H) @(negedge clk);
    PS2_clk = 1'b0;
    repeat (H) @(negedge clk);
    PS2_clk = 1'b1;
  endtask
  task automatic frame(input string tag, input logic [7:0] c, input bit bp = 0, input bit bs = 0);
    int e0, f0, k0;
    e0 = ev_cnt;
    f0 = err_cnt;
    k0 = m_key;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit(~(^c) ^ bp);
    ps2_bit(~bs);
    @(negedge clk) PS2_data = 1'b1;
    repeat (4) @(negedge clk);
    model(c, bp | bs);
    chk({tag, "_key"}, int'(key), m_key);
    chk({tag, "_ev"}, ev_cnt - e0, (m_key != k0) ? 1 : 0);
    chk({tag, "_err"}, err_cnt - f0, (bp | bs) ? 1 : 0);
  endtask
  initial begin
    logic [7:0] c29, pool [12];
    int e0, f0;
    c29  = 8'h29;
    pool = '{8'hE0, 8'hF0, 8'h29, 8'h2D, 8'h1A, 8'h75, 8'h6B, 8'h74, 8'h72, 8'h12, 8'hE0, 8'hF0};
    repeat (5) @(negedge clk);
    chk("rst_key", int'(key), 0);
    chk("rst_ev", int'(key_event), 0);
    chk("rst_err", int'(frame_err), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    e0 = ev_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c29[i]);
    ps2_bit(~(^c29));
    @(negedge clk) PS2_data = 1'b1;
    repeat (H) @(negedge clk);
    PS2_clk = 1'b0;
    repeat (SS + 1) @(negedge clk);
    chk("lat_early_key", int'(key), 0);
    @(negedge clk);
    chk("lat_key", int'(key), 2);
    chk("lat_ev", int'(key_event), 1);
    @(negedge clk);
    chk("lat_ev_off", int'(key_event), 0);
    repeat (H) @(negedge clk);
    PS2_clk = 1'b1;
    repeat (4) @(negedge clk);
    model(8'h29, 0);
    chk("t1_evcount", ev_cnt - e0, 1);
    frame("t1_f0", 8'hF0);
    frame("t1_brk", 8'h29);
    frame("t2_e0a", 8'hE0);
    frame("t2_left", 8'h6B);
    frame("t2_e0b", 8'hE0);
    frame("t2_right", 8'h74);
    frame("t2_e0c", 8'hE0);
    frame("t2_f0c", 8'hF0);
    frame("t2_brkl", 8'h6B);
    frame("t2_e0d", 8'hE0);
    frame("t2_f0d", 8'hF0);
    frame("t2_brkr", 8'h74);
    e0 = ev_cnt;
    for (int i = 0; i < 3; i++) frame("t3_typ", 8'h1A);
    chk("t3_evtotal", ev_cnt - e0, 1);
    frame("t4_badpar", 8'h2D, 1);
    frame("t4_good", 8'h2D);
    f0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TO + 1 + H) @(negedge clk);
    model(8'h00, 1);
    chk("t5_timeout_err", err_cnt - f0, 1);
    frame("t5_after", 8'h29);
    frame("t5_badstop", 8'h1A, 0, 1);
    frame("t6_e0", 8'hE0);
    frame("t6_cw", 8'h75);
    frame("t6_e0b", 8'hE0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk) PS2_clk = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    PS2_clk = 1'b1;
    PS2_data = 1'b1;
    #1 chk("t6_async_key", int'(key), 0);
    m_key = 0;
    m_ext = 0;
    m_brk = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    frame("t6_noext", 8'h75);
    frame("t6_e0c", 8'hE0);
    frame("t6_cw2", 8'h75);
    for (int n = 0; n < 40; n++) begin
      logic [7:0] c;
      bit er;
      c  = pool[$urandom_range(0, 11)];
      er = ($urandom_range(0, 9) == 0);
      frame("rnd", c, er & $urandom_range(0, 1), er);
    end
    chk("never_both", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
